mem_access_stage: RTL and testbench

- Load/store memory stage directly downstream of the execute stage.
- Consumes the registered LSQ outputs of execute: address, store data, size/sign control, destination register, MemRead/MemWrite/MemtoReg.
- Performs sub-word alignment, drives a valid/ready data-memory port and freezes upstream while an access is in flight.
- Returns load results to commit as the LS forwarding triple (data, reg, flag).

---
 rtl/mem_access_stage_if.sv | 23 ++
 rtl/mem_access_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/response port bundle for mem_access_stage
interface mem_access_stage_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;

    // The memory stage issues requests and consumes responses.
    modport master (
        output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        input  dmem_req_ready, dmem_resp_valid, dmem_rdata
    );

    // The data memory accepts requests and returns read data.
    modport slave (
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        output dmem_req_ready, dmem_resp_valid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store memory stage with sub-word alignment; optional MEM_ALIGN_CHECK_EN adds align_fault
module mem_access_stage #(
    parameter int unsigned MAX_WAIT   = 255,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] address,
    input  logic [31:0] readDataB1_PR,
    input  logic [5:0]  ALU_control1_PR,
    input  logic [5:0]  LS_destination_out,
    input  logic        MemRead1_PR,
    input  logic        MemWrite1_PR,
    output logic        FREEZE,
    mem_access_stage_if.master dmem,
    output logic [31:0] LS_fwd_data_COM,
    output logic [5:0]  LS_fwd_reg_COM,
    output logic        LS_fwd_data_COM_flag,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        align_fault,
`endif
    output logic        bus_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state;
    state_t      state_n;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_inc;

    // Fields of the access in flight, needed to shape the load result.
    logic [1:0]  cap_off;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic        cap_load;
    logic [5:0]  cap_dest;

    logic [1:0]  in_off;
    logic [1:0]  in_size;
    logic        accept;
    logic        issue;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;

    logic [1:0]  byte_pos;
    logic        half_hi;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;

    logic        unused_ctrl_bits;

    assign unused_ctrl_bits = ^ALU_control1_PR[5:3];

    assign in_off   = address[1:0];
    assign in_size  = ALU_control1_PR[1:0];
    assign accept   = (state == S_IDLE) && (MemRead1_PR || MemWrite1_PR);
    assign wait_inc = wait_cnt + 8'd1;
    assign FREEZE   = (state != S_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    logic fault;
    // Byte accesses can never be misaligned; half needs even, word needs zero offset.
    assign misaligned = ((in_size == 2'b01) && in_off[0]) || (in_size[1] && (in_off != 2'b00));
    assign issue      = accept && !misaligned;
    assign fault      = accept && misaligned;
`else
    assign issue      = accept;
`endif

    // Byte enables and lane-replicated store data for the op being captured.
    always_comb begin
        in_be    = 4'b0000;
        in_wdata = 32'h0;
        case (in_size)
            2'b00: begin
                in_be    = BIG_ENDIAN ? (4'b1000 >> in_off) : (4'b0001 << in_off);
                in_wdata = {4{readDataB1_PR[7:0]}};
            end
            2'b01: begin
                in_be    = (in_off[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
                in_wdata = {2{readDataB1_PR[15:0]}};
            end
            default: begin
                in_be    = 4'b1111;
                in_wdata = readDataB1_PR;
            end
        endcase
    end

    assign byte_pos = BIG_ENDIAN ? ~cap_off : cap_off;
    assign half_hi  = cap_off[1] ^ BIG_ENDIAN;
    assign half_v   = half_hi ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    // Pick the addressed lane out of the raw word, then zero- or sign-extend it.
    always_comb begin
        byte_v   = 8'h0;
        load_val = 32'h0;
        case (byte_pos)
            2'd0:    byte_v = dmem.dmem_rdata[7:0];
            2'd1:    byte_v = dmem.dmem_rdata[15:8];
            2'd2:    byte_v = dmem.dmem_rdata[23:16];
            default: byte_v = dmem.dmem_rdata[31:24];
        endcase
        case (cap_size)
            2'b00:   load_val = cap_uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_val = cap_uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_val = dmem.dmem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: capture, handshake, response or timeout.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_n = S_REQ;
                end
`ifdef MEM_ALIGN_CHECK_EN
                else if (fault) begin
                    state_n = S_FAULT;
                end
`endif
            end
            S_REQ: begin
                if (dmem.dmem_req_ready) begin
                    state_n = cap_load ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                if (dmem.dmem_resp_valid || (wait_inc == WAIT_LIMIT)) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered datapath: capture fields, drive the memory port, write back results.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt             <= 8'h0;
            cap_off              <= 2'b00;
            cap_size             <= 2'b00;
            cap_uns              <= 1'b0;
            cap_load             <= 1'b0;
            cap_dest             <= 6'h0;
            dmem.dmem_req_valid  <= 1'b0;
            dmem.dmem_addr       <= 32'h0;
            dmem.dmem_we         <= 1'b0;
            dmem.dmem_be         <= 4'b0000;
            dmem.dmem_wdata      <= 32'h0;
            LS_fwd_data_COM      <= 32'h0;
            LS_fwd_reg_COM       <= 6'h0;
            LS_fwd_data_COM_flag <= 1'b0;
            bus_error            <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_fault          <= 1'b0;
`endif
        end else begin
            LS_fwd_data_COM_flag <= 1'b0;
            bus_error            <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_fault          <= fault;
`endif
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wait_cnt <= 8'h0;
                        cap_off  <= in_off;
                        cap_size <= in_size;
                        cap_uns  <= ALU_control1_PR[2];
                        cap_load <= MemRead1_PR;
                        cap_dest <= LS_destination_out;
                    end
                    if (issue) begin
                        dmem.dmem_req_valid <= 1'b1;
                        dmem.dmem_addr      <= {address[31:2], 2'b00};
                        dmem.dmem_we        <= MemWrite1_PR && !MemRead1_PR;
                        dmem.dmem_be        <= in_be;
                        dmem.dmem_wdata     <= in_wdata;
                    end
                end
                S_REQ: begin
                    if (dmem.dmem_req_ready) begin
                        dmem.dmem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_resp_valid) begin
                        LS_fwd_data_COM      <= load_val;
                        LS_fwd_reg_COM       <= cap_dest;
                        LS_fwd_data_COM_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == WAIT_LIMIT) begin
                            bus_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    localparam int unsigned TB_MAX_WAIT = 12;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] address;
    logic [31:0] readDataB1_PR;
    logic [5:0]  ALU_control1_PR;
    logic [5:0]  LS_destination_out;
    logic        MemRead1_PR;
    logic        MemWrite1_PR;
    logic        FREEZE;
    logic [31:0] LS_fwd_data_COM;
    logic [5:0]  LS_fwd_reg_COM;
    logic        LS_fwd_data_COM_flag;
    logic        bus_error;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    mem_access_stage_if dmem();

    mem_access_stage #(.MAX_WAIT(TB_MAX_WAIT), .BIG_ENDIAN(1'b1)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .address              (address),
        .readDataB1_PR        (readDataB1_PR),
        .ALU_control1_PR      (ALU_control1_PR),
        .LS_destination_out   (LS_destination_out),
        .MemRead1_PR          (MemRead1_PR),
        .MemWrite1_PR         (MemWrite1_PR),
        .FREEZE               (FREEZE),
        .dmem                 (dmem.master),
        .LS_fwd_data_COM      (LS_fwd_data_COM),
        .LS_fwd_reg_COM       (LS_fwd_reg_COM),
        .LS_fwd_data_COM_flag (LS_fwd_data_COM_flag),
`ifdef MEM_ALIGN_CHECK_EN
        .align_fault          (align_fault),
`endif
        .bus_error            (bus_error)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wd;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  rg;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int freeze_cnt = 0;
    int valid_cnt = 0;
    int flag_cnt = 0;
    int berr_cnt = 0;
    int fault_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] o);
        logic [3:0] r;
        r = 4'b0000;
        case (sz)
            2'b00:   r[3 - int'(o)] = 1'b1;
            2'b01:   r = o[1] ? 4'b0011 : 4'b1100;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b01:   return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] o, input logic [31:0] w);
        logic [7:0] b [4];
        logic [15:0] h;
        int k;
        for (int i = 0; i < 4; i++) b[i] = w[31 - 8 * i -: 8];
        case (sz)
            2'b00: return uns ? {24'h0, b[o]} : {{24{b[o][7]}}, b[o]};
            2'b01: begin
                k = o[1] ? 2 : 0;
                h = {b[k], b[k + 1]};
                return uns ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return w;
        endcase
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic m_misaligned(input logic [1:0] sz, input logic [1:0] o);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return o[0];
        return o != 2'b00;
    endfunction
`endif

    // Observe the DUT away from the rising edge and score requests and writebacks.
    always @(negedge CLK) begin
        if (FREEZE) freeze_cnt++;
        if (bus_error) berr_cnt++;
`ifdef MEM_ALIGN_CHECK_EN
        if (align_fault) fault_cnt++;
`endif
        if (dmem.dmem_req_valid) begin
            valid_cnt++;
            if (req_q.size() == 0) begin
                chk("req_unexpected", 32'(req_q.size()), 32'd1);
            end else begin
                chk("req_addr", dmem.dmem_addr, req_q[0].addr);
                chk("req_we", 32'(dmem.dmem_we), 32'(req_q[0].we));
                chk("req_be", 32'(dmem.dmem_be), 32'(req_q[0].be));
                if (req_q[0].chk_wd) chk("req_wdata", dmem.dmem_wdata, req_q[0].wdata);
                if (dmem.dmem_req_ready) void'(req_q.pop_front());
            end
        end
        if (LS_fwd_data_COM_flag) begin
            flag_cnt++;
            if (wb_q.size() == 0) begin
                chk("wb_unexpected", 32'(wb_q.size()), 32'd1);
            end else begin
                chk("wb_data", LS_fwd_data_COM, wb_q[0].data);
                chk("wb_reg", 32'(LS_fwd_reg_COM), 32'(wb_q[0].rg));
                void'(wb_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_counts();
        freeze_cnt = 0;
        valid_cnt  = 0;
        flag_cnt   = 0;
        berr_cnt   = 0;
        fault_cnt  = 0;
    endtask

    task automatic drive_op(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [5:0] c, input logic [5:0] dst);
        req_t r;
        logic skip;
        MemRead1_PR        = rd;
        MemWrite1_PR       = wr;
        address            = a;
        readDataB1_PR      = d;
        ALU_control1_PR    = c;
        LS_destination_out = dst;
        r.addr   = {a[31:2], 2'b00};
        r.we     = wr & ~rd;
        r.be     = m_be(c[1:0], a[1:0]);
        r.wdata  = m_wdata(c[1:0], d);
        r.chk_wd = r.we;
        skip = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        skip = m_misaligned(c[1:0], a[1:0]);
`endif
        if (!skip) req_q.push_back(r);
    endtask

    // Wait for the rising edge at which the stage takes the presented op, then retire it.
    task automatic wait_capture(output int waits);
        logic got;
        got   = 1'b0;
        waits = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            waits = i;
            if (!FREEZE) begin
                got = 1'b1;
                break;
            end
        end
        chk("capture_seen", 32'(got), 32'd1);
        @(posedge CLK);
        #1;
        MemRead1_PR  = 1'b0;
        MemWrite1_PR = 1'b0;
    endtask

    // Play the memory: ready after rdy_dly cycles, response resp_dly cycles after the handshake.
    task automatic serve(input int rdy_dly, input logic is_load, input logic give_resp,
                         input int resp_dly, input logic [31:0] word, input wb_t exp_wb);
        idle(rdy_dly);
        dmem.dmem_req_ready = 1'b1;
        @(posedge CLK);
        #1;
        dmem.dmem_req_ready = 1'b0;
        if (is_load && give_resp) begin
            idle(resp_dly);
            dmem.dmem_resp_valid = 1'b1;
            dmem.dmem_rdata      = word;
            wb_q.push_back(exp_wb);
            @(posedge CLK);
            #1;
            dmem.dmem_resp_valid = 1'b0;
        end
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [5:0] c, input logic [5:0] dst, input int rdy_dly,
                          input int resp_dly, input logic [31:0] word);
        int w;
        wb_t e;
        drive_op(rd, wr, a, d, c, dst);
        wait_capture(w);
        e.data = m_load(c[1:0], c[2], a[1:0], word);
        e.rg   = dst;
        serve(rdy_dly, rd, 1'b1, resp_dly, word, e);
        idle(2);
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "_freeze"}, 32'(FREEZE), 32'd0);
        chk({pfx, "_req_valid"}, 32'(dmem.dmem_req_valid), 32'd0);
        chk({pfx, "_we"}, 32'(dmem.dmem_we), 32'd0);
        chk({pfx, "_be"}, 32'(dmem.dmem_be), 32'd0);
        chk({pfx, "_addr"}, dmem.dmem_addr, 32'd0);
        chk({pfx, "_wdata"}, dmem.dmem_wdata, 32'd0);
        chk({pfx, "_fwd_data"}, LS_fwd_data_COM, 32'd0);
        chk({pfx, "_fwd_reg"}, 32'(LS_fwd_reg_COM), 32'd0);
        chk({pfx, "_flag"}, 32'(LS_fwd_data_COM_flag), 32'd0);
        chk({pfx, "_bus_error"}, 32'(bus_error), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        wb_t e;

        RESET                = 1'b1;
        address              = 32'h0;
        readDataB1_PR        = 32'h0;
        ALU_control1_PR      = 6'h0;
        LS_destination_out   = 6'h0;
        MemRead1_PR          = 1'b0;
        MemWrite1_PR         = 1'b0;
        dmem.dmem_req_ready  = 1'b0;
        dmem.dmem_resp_valid = 1'b0;
        dmem.dmem_rdata      = 32'h0;
        idle(2);
        @(negedge CLK);
        check_reset("rst");
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle(1);

        // Signed byte load, immediate ready and response.
        clear_counts();
        run_op(1'b1, 1'b0, 32'h0000_1003, 32'h0, 6'b000000, 6'd5, 0, 0, 32'h1122_3380);
        chk("t1_data", LS_fwd_data_COM, 32'hFFFF_FF80);
        chk("t1_reg", 32'(LS_fwd_reg_COM), 32'd5);
        chk("t1_freeze_cycles", 32'(freeze_cnt), 32'd2);
        chk("t1_flag_pulses", 32'(flag_cnt), 32'd1);

        // Half store with ready held low for three cycles.
        clear_counts();
        run_op(1'b0, 1'b1, 32'h0000_2002, 32'h0000_ABCD, 6'b000001, 6'd0, 3, 0, 32'h0);
        chk("t2_valid_cycles", 32'(valid_cnt), 32'd4);
        chk("t2_freeze_cycles", 32'(freeze_cnt), 32'd4);
        chk("t2_flag_pulses", 32'(flag_cnt), 32'd0);

        // Unsigned half load with a slow response while execute holds the next op.
        clear_counts();
        drive_op(1'b1, 1'b0, 32'h0000_0000, 32'h0, 6'b000101, 6'd7);
        wait_capture(w);
        drive_op(1'b0, 1'b1, 32'h0000_0041, 32'h0000_005A, 6'b000000, 6'd0);
        e.data = 32'h0000_8001;
        e.rg   = 6'd7;
        serve(0, 1'b1, 1'b1, 10, 32'h8001_FFFF, e);
        chk("t3_freeze_cycles", 32'(freeze_cnt), 32'd12);
        wait_capture(w);
        chk("t3_held_capture_wait", 32'(w), 32'd1);
        chk("t3_data", LS_fwd_data_COM, 32'h0000_8001);
        serve(1, 1'b0, 1'b0, 0, 32'h0, e);
        idle(2);
        chk("t3_req_drained", 32'(req_q.size()), 32'd0);
        chk("t3_flag_pulses", 32'(flag_cnt), 32'd1);

        // Load that never gets a response times out.
        clear_counts();
        drive_op(1'b1, 1'b0, 32'h0000_0050, 32'h0, 6'b000010, 6'd9);
        wait_capture(w);
        serve(0, 1'b1, 1'b0, 0, 32'h0, e);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            n = i;
            if (bus_error) break;
        end
        chk("t4_timeout_cycles", 32'(n), 32'(TB_MAX_WAIT + 1));
        idle(2);
        chk("t4_bus_error_pulses", 32'(berr_cnt), 32'd1);
        chk("t4_freeze_cycles", 32'(freeze_cnt), 32'(TB_MAX_WAIT + 1));
        dmem.dmem_resp_valid = 1'b1;
        dmem.dmem_rdata      = 32'h5555_5555;
        idle(1);
        dmem.dmem_resp_valid = 1'b0;
        idle(3);
        chk("t4_late_resp_flags", 32'(flag_cnt), 32'd0);

        // Reset in the middle of a load wait.
        clear_counts();
        drive_op(1'b1, 1'b0, 32'h0000_0060, 32'h0, 6'b000010, 6'd10);
        wait_capture(w);
        serve(0, 1'b1, 1'b0, 0, 32'h0, e);
        idle(2);
        chk("t5_in_wait_freeze", 32'(FREEZE), 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check_reset("t5");
        #1;
        dmem.dmem_resp_valid = 1'b1;
        dmem.dmem_rdata      = 32'h7777_7777;
        idle(1);
        dmem.dmem_resp_valid = 1'b0;
        idle(3);
        chk("t5_late_resp_flags", 32'(flag_cnt), 32'd0);
        chk("t5_bus_error_pulses", 32'(berr_cnt), 32'd0);

        // Assorted lanes, extensions and encodings.
        clear_counts();
        run_op(1'b1, 1'b0, 32'h0000_1001, 32'h0, 6'b000100, 6'd12, 1, 2, 32'hA1B2_C3D4);
        chk("x_ubyte", LS_fwd_data_COM, 32'h0000_00B2);
        run_op(1'b1, 1'b0, 32'h0000_0002, 32'h0, 6'b000001, 6'd13, 0, 1, 32'h1234_F00D);
        chk("x_shalf", LS_fwd_data_COM, 32'hFFFF_F00D);
        run_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, 6'b111011, 6'd14, 0, 0, 32'hCAFE_BABE);
        chk("x_reserved_size", LS_fwd_data_COM, 32'hCAFE_BABE);
        run_op(1'b1, 1'b1, 32'h0000_0020, 32'h9999_9999, 6'b000010, 6'd15, 2, 0, 32'h0BAD_F00D);
        chk("x_rd_wr_load", LS_fwd_data_COM, 32'h0BAD_F00D);
        run_op(1'b0, 1'b1, 32'h0000_0030, 32'h0123_4567, 6'b000010, 6'd0, 1, 0, 32'h0);
        run_op(1'b0, 1'b1, 32'h0000_0030, 32'h0000_00EE, 6'b000000, 6'd0, 0, 0, 32'h0);
        chk("x_flag_pulses", 32'(flag_cnt), 32'd4);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word is refused without touching memory.
        clear_counts();
        drive_op(1'b1, 1'b0, 32'h0000_3002, 32'h0, 6'b000010, 6'd11);
        wait_capture(w);
        idle(3);
        chk("t6_align_fault_pulses", 32'(fault_cnt), 32'd1);
        chk("t6_valid_cycles", 32'(valid_cnt), 32'd0);
        chk("t6_freeze_cycles", 32'(freeze_cnt), 32'd1);
        chk("t6_flag_pulses", 32'(flag_cnt), 32'd0);
`else
        // Misaligned accesses ignore the low address bits.
        run_op(1'b1, 1'b0, 32'h0000_3002, 32'h0, 6'b000010, 6'd11, 0, 0, 32'hDEAD_BEEF);
        chk("t6_misaligned_word", LS_fwd_data_COM, 32'hDEAD_BEEF);
        run_op(1'b1, 1'b0, 32'h0000_0005, 32'h0, 6'b000101, 6'd16, 0, 0, 32'h8001_2345);
        chk("t6_misaligned_half", LS_fwd_data_COM, 32'h0000_8001);
`endif

        chk("end_req_queue_empty", 32'(req_q.size()), 32'd0);
        chk("end_wb_queue_empty", 32'(wb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
